imem_responder: RTL and testbench



---
 rtl/imem_responder.sv | 103 ++++++++++
 tb/tb_imem_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: pc-indexed fetches, fixed-latency read pipeline, in-order response FIFO.
// Optional out-of-range address check enabled by defining IMEM_ADDR_CHECK_EN.
module imem_responder #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WORD_SIZE-1:0]     rsp_instruction,
  output logic                     rsp_error,
  input  logic                     load_enable,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]     load_data,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int FD = LATENCY + 2;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] rd_data;
  logic                 rd_err;
  logic                 accept, push, pop;

  logic [LATENCY:1]     vld_pipe_q;
  logic [WORD_SIZE-1:0] dat_pipe_q [1:LATENCY];
  logic [WORD_SIZE-1:0] fifo_dat_q [FD];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        fcnt_q, fcnt_d, out_q, out_d;

  assign req_ready = !load_enable && (out_q < CW'(FD));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fcnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = vld_pipe_q[LATENCY];
  assign busy      = (out_q != '0);

`ifdef IMEM_ADDR_CHECK_EN
  localparam logic [WORD_SIZE-1:0] NOP = WORD_SIZE'(32'h0000_0013);
  logic [LATENCY:1] err_pipe_q;
  logic [FD-1:0]    fifo_err_q;

  assign rd_err    = (req_addr >= 32'(DEPTH));
  assign rd_data   = rd_err ? NOP : mem_q[req_addr[AW-1:0]];
  assign rsp_error = rsp_valid && fifo_err_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    err_pipe_q[1] <= rd_err;
    for (int i = 2; i <= LATENCY; i++) err_pipe_q[i] <= err_pipe_q[i-1];
    if (push) fifo_err_q[wr_ptr_q] <= err_pipe_q[LATENCY];
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];
  assign rd_err    = 1'b0;
  assign rd_data   = mem_q[req_addr[AW-1:0]];
  assign rsp_error = rd_err;
`endif

  // Gate the head so the data output reads zero whenever nothing is buffered.
  assign rsp_instruction = rsp_valid ? fifo_dat_q[rd_ptr_q] : '0;

  always_comb begin
    out_d    = out_q + CW'(accept) - CW'(pop);
    fcnt_d   = fcnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FD-1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FD-1)) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      out_q      <= '0;
      fcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_pipe_q[1] <= accept;
      for (int i = 2; i <= LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      out_q    <= out_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data paths carry no reset; validity is tracked by the reset control above.
  always_ff @(posedge clock) begin
    if (load_enable) mem_q[load_addr] <= load_data;
    dat_pipe_q[1] <= rd_data;
    for (int i = 2; i <= LATENCY; i++) dat_pipe_q[i] <= dat_pipe_q[i-1];
    if (push) fifo_dat_q[wr_ptr_q] <= dat_pipe_q[LATENCY];
  end
endmodule

// File: tb/tb_imem_responder.sv
// Directed scoreboard bench for imem_responder (default parameters).
module tb_imem_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instruction;
  logic        rsp_error;
  logic        load_enable = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] tb_mem [64];
  logic [32:0] exp_q [$];

  imem_responder dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instruction(rsp_instruction), .rsp_error(rsp_error),
    .load_enable(load_enable), .load_addr(load_addr), .load_data(load_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] model(input logic [31:0] a);
`ifdef IMEM_ADDR_CHECK_EN
    if (a >= 32'd64) return {1'b1, 32'h0000_0013};
`endif
    return {1'b0, tb_mem[a[5:0]]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes before the edge, then advance to just past it.
  task automatic cyc();
    logic [32:0] e;
    #1;
    if (req_valid && req_ready) exp_q.push_back(model(req_addr));
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", {31'd0, rsp_error, rsp_instruction}, {31'd0, e});
      end
    end
    if (load_enable) tb_mem[load_addr] = load_data;
    @(posedge clock); #1;
  endtask

  task automatic drain(input string tag);
    req_valid = 1'b0; rsp_ready = 1'b1; load_enable = 1'b0;
    for (int i = 0; i < 20 && (busy || exp_q.size() != 0); i++) cyc();
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    load_enable = 1'b1; load_addr = a; load_data = d;
    cyc();
    load_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h00A00093; words[1] = 32'h01400113;
    words[2] = 32'h002081B3; words[3] = 32'h00000013;

    // reset state
    #2;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_instr", 64'(rsp_instruction), 64'd0);
    chk("rst_err", 64'(rsp_error), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clock); #1;
    reset = 1'b0;

    // program load
    load_enable = 1'b1; #1;
    chk("load_req_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 4; i++) load(6'(i), words[i]);
    load(6'd5, 32'hDEADBEEF);

    // back-to-back fetch, latency and in-order return
    rsp_ready = 1'b1; req_valid = 1'b1;
    req_addr = 32'd0; cyc();
    req_addr = 32'd1; cyc();
    chk("lat_early", 64'(rsp_valid), 64'd0);
    req_addr = 32'd2; cyc();
    chk("lat_valid", 64'(rsp_valid), 64'd1);
    chk("lat_head", 64'(rsp_instruction), 64'(words[0]));
    req_addr = 32'd3; cyc();
    chk("steady_ready", 64'(req_ready), 64'd1);
    drain("t1");

    // back-pressure: FIFO fills, holds, then drains
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin req_addr = 32'(i % 4); cyc(); end
    chk("bp_accepted", 64'(exp_q.size()), 64'd4);
    chk("bp_req_ready", 64'(req_ready), 64'd0);
    chk("bp_valid", 64'(rsp_valid), 64'd1);
    cyc();
    chk("bp_hold", {31'd0, rsp_error, rsp_instruction}, {31'd0, exp_q[0]});
    req_valid = 1'b0; rsp_ready = 1'b1; #1;
    chk("bp_ready_before_pop", 64'(req_ready), 64'd0);
    cyc();
    chk("bp_ready_after_pop", 64'(req_ready), 64'd1);
    drain("t2");

    // read happens at acceptance; load blocks acceptance
    req_valid = 1'b1; req_addr = 32'd5; cyc();
    load_enable = 1'b1; load_addr = 6'd5; load_data = 32'h12345678; #1;
    chk("load_blocks", 64'(req_ready), 64'd0);
    cyc();
    load_enable = 1'b0; #1;
    chk("load_release", 64'(req_ready), 64'd1);
    cyc();
    drain("t3");

    // out-of-range address
    req_valid = 1'b1; req_addr = 32'd64; cyc();
    drain("t4");

    // reset with responses outstanding
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin req_addr = 32'(i); cyc(); end
    req_valid = 1'b0; cyc();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1; #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_idle", 64'(rsp_valid), 64'd0);
      cyc();
    end
    req_valid = 1'b1; req_addr = 32'd2; cyc();
    drain("t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
